// File: rtl/writeback_unit.sv
// writeback_unit: merges integer results and buffered load results onto one register-file write port.
// Define WRITEBACK_FORWARD_EN to drive the combinational forwarding bus; otherwise it is tied to zero.
module writeback_unit #(
  parameter int XLEN = 32,
  parameter int MEM_FIFO_DEPTH = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_int_valid,
  input  logic [XLEN-1:0]                   i_int_res,
  input  logic [4:0]                        i_int_waddr,
  input  logic                              i_mem_valid,
  output logic                              o_mem_ready,
  input  logic [XLEN-1:0]                   i_mem_data,
  input  logic [4:0]                        i_mem_waddr,
  output logic [$clog2(MEM_FIFO_DEPTH):0]   o_mem_count,
  output logic                              o_rf_wen,
  output logic [4:0]                        o_rf_waddr,
  output logic [XLEN-1:0]                   o_rf_wdata,
  output logic                              o_fwd_valid,
  output logic [4:0]                        o_fwd_waddr,
  output logic [XLEN-1:0]                   o_fwd_data
);
  localparam int AW = $clog2(MEM_FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [XLEN-1:0] fifo_data_q [MEM_FIFO_DEPTH];
  logic [XLEN-1:0] fifo_data_d [MEM_FIFO_DEPTH];
  logic [4:0]      fifo_addr_q [MEM_FIFO_DEPTH];
  logic [4:0]      fifo_addr_d [MEM_FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            rf_wen_q, rf_wen_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic            push, pop, sel_valid;
  logic [4:0]      sel_waddr;
  logic [XLEN-1:0] sel_data;
  assign o_mem_ready = !rst && (count_q != CW'(MEM_FIFO_DEPTH));
  assign o_mem_count = rst ? '0 : count_q;
  assign o_rf_wen    = rf_wen_q && !rst;
  assign o_rf_waddr  = rst ? '0 : rf_waddr_q;
  assign o_rf_wdata  = rst ? '0 : rf_wdata_q;
  always_comb begin
    push        = i_mem_valid && o_mem_ready;
    pop         = !i_int_valid && (count_q != '0);
    sel_valid   = i_int_valid || pop;
    sel_waddr   = i_int_valid ? i_int_waddr : pop ? fifo_addr_q[rd_ptr_q] : '0;
    sel_data    = i_int_valid ? i_int_res : pop ? fifo_data_q[rd_ptr_q] : '0;
    fifo_data_d = fifo_data_q;
    fifo_addr_d = fifo_addr_q;
    if (push) begin
      fifo_data_d[wr_ptr_q] = i_mem_data;
      fifo_addr_d[wr_ptr_q] = i_mem_waddr;
    end
    wr_ptr_d    = wr_ptr_q + AW'(push);
    rd_ptr_d    = rd_ptr_q + AW'(pop);
    count_d     = count_q + CW'(push) - CW'(pop);
    rf_wen_d    = sel_valid && (sel_waddr != '0);
    rf_waddr_d  = sel_valid ? sel_waddr : rf_waddr_q;
    rf_wdata_d  = sel_valid ? sel_data : rf_wdata_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_data_q <= '{default: '0};
      fifo_addr_q <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rf_wen_q    <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
    end else begin
      fifo_data_q <= fifo_data_d;
      fifo_addr_q <= fifo_addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rf_wen_q    <= rf_wen_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
    end
  end
`ifdef WRITEBACK_FORWARD_EN
  assign o_fwd_valid = !rst && sel_valid && (sel_waddr != '0);
  assign o_fwd_waddr = rst ? '0 : sel_waddr;
  assign o_fwd_data  = rst ? '0 : sel_data;
`else
  assign o_fwd_valid = 1'b0;
  assign o_fwd_waddr = '0;
  assign o_fwd_data  = '0;
`endif
`ifndef SYNTHESIS
  // An integer write overtaking a still-buffered load to the same register would be undone by the older load.
  logic waw_hit;
  always_comb begin
    waw_hit = 1'b0;
    for (int i = 0; i < MEM_FIFO_DEPTH; i++)
      if (CW'(i) < count_q && fifo_addr_q[rd_ptr_q + AW'(i)] == i_int_waddr) waw_hit = 1'b1;
  end
  waw_hazard: assert property (@(posedge clk) disable iff (rst)
    !(i_int_valid && i_int_waddr != '0 && waw_hit))
    else $error("writeback_unit: WAW hazard on x%0d", i_int_waddr);
`endif
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed vector table plus randomized traffic checked against a queue-based model.
module tb_writeback_unit;
  localparam int XLEN = 32;
  localparam int DEPTH = 2;
  logic            clk = 1'b0;
  logic            rst;
  logic            i_int_valid, i_mem_valid, o_mem_ready;
  logic [XLEN-1:0] i_int_res, i_mem_data, o_rf_wdata, o_fwd_data;
  logic [4:0]      i_int_waddr, i_mem_waddr, o_rf_waddr, o_fwd_waddr;
  logic [1:0]      o_mem_count;
  logic            o_rf_wen, o_fwd_valid;
  int tests = 0;
  int fails = 0;
  writeback_unit #(.XLEN(XLEN), .MEM_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .i_int_valid(i_int_valid), .i_int_res(i_int_res), .i_int_waddr(i_int_waddr),
    .i_mem_valid(i_mem_valid), .o_mem_ready(o_mem_ready), .i_mem_data(i_mem_data),
    .i_mem_waddr(i_mem_waddr), .o_mem_count(o_mem_count),
    .o_rf_wen(o_rf_wen), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata),
    .o_fwd_valid(o_fwd_valid), .o_fwd_waddr(o_fwd_waddr), .o_fwd_data(o_fwd_data)
  );
  always #5 clk = ~clk;
  typedef struct packed { logic [4:0] a; logic [31:0] d; } ent_t;
  ent_t q[$];
  logic exp_wen;
  logic [4:0] exp_waddr;
  logic [31:0] exp_wdata;
  typedef struct {
    logic iv; logic [4:0] ia; logic [31:0] id;
    logic mv; logic [4:0] ma; logic [31:0] md;
    logic wen; logic [4:0] wa; logic [31:0] wd; logic [1:0] cnt; logic rdy;
  } vec_t;
  vec_t tbl[17];
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s got %0h want %0h at %0t", n, act, req, $time);
    end
  endtask
  task automatic drive(input logic iv, input logic [4:0] ia, input logic [31:0] id,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    i_int_valid = iv; i_int_waddr = ia; i_int_res = id;
    i_mem_valid = mv; i_mem_waddr = ma; i_mem_data = md;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #4;
    chk("rst_wen", o_rf_wen, 0);
    chk("rst_waddr", o_rf_waddr, 0);
    chk("rst_wdata", o_rf_wdata, 0);
    chk("rst_count", o_mem_count, 0);
    chk("rst_ready", o_mem_ready, 0);
    chk("rst_fwd", {o_fwd_valid, o_fwd_waddr, o_fwd_data}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    exp_wen = 0; exp_waddr = 0; exp_wdata = 0;
  endtask
  // One cycle against the model: outputs are checked mid-cycle, then the model advances at the edge.
  task automatic step(input logic iv, input logic [4:0] ia, input logic [31:0] id,
                      input logic mv, input logic [4:0] ma, input logic [31:0] md);
    logic has; ent_t s; logic acc;
    drive(iv, ia, id, mv, ma, md);
    #4;
    chk("rf_wen", o_rf_wen, exp_wen);
    chk("rf_waddr", o_rf_waddr, exp_waddr);
    chk("rf_wdata", o_rf_wdata, exp_wdata);
    chk("mem_count", o_mem_count, 64'(q.size()));
    chk("mem_ready", o_mem_ready, q.size() < DEPTH);
    acc = mv && q.size() < DEPTH;
    has = iv || q.size() > 0;
    s = iv ? ent_t'{ia, id} : q.size() > 0 ? q[0] : ent_t'(0);
`ifdef WRITEBACK_FORWARD_EN
    chk("fwd", {o_fwd_valid, o_fwd_waddr, o_fwd_data}, {has && s.a != 0, has ? s : ent_t'(0)});
`else
    chk("fwd", {o_fwd_valid, o_fwd_waddr, o_fwd_data}, 0);
`endif
    if (!iv && q.size() > 0) void'(q.pop_front());
    if (has) begin
      exp_wen = s.a != 0; exp_waddr = s.a; exp_wdata = s.d;
    end else exp_wen = 0;
    if (acc) q.push_back({ma, md});
    @(posedge clk); #1;
  endtask
  initial begin
    tbl[0]  = '{1, 5, 32'h1234, 0, 0, 0,             0, 0,  0,            0, 1};
    tbl[1]  = '{0, 0, 0, 0, 0, 0,                     1, 5,  32'h1234,     0, 1};
    tbl[2]  = '{0, 0, 0, 1, 7, 32'hDEADBEEF,          0, 5,  32'h1234,     0, 1};
    tbl[3]  = '{0, 0, 0, 0, 0, 0,                     0, 5,  32'h1234,     1, 1};
    tbl[4]  = '{0, 0, 0, 0, 0, 0,                     1, 7,  32'hDEADBEEF, 0, 1};
    tbl[5]  = '{0, 0, 0, 0, 0, 0,                     0, 7,  32'hDEADBEEF, 0, 1};
    tbl[6]  = '{1, 1, 32'h11, 1, 20, 32'hA0,          0, 7,  32'hDEADBEEF, 0, 1};
    tbl[7]  = '{1, 2, 32'h22, 1, 21, 32'hA1,          1, 1,  32'h11,       1, 1};
    tbl[8]  = '{1, 3, 32'h33, 1, 22, 32'hA2,          1, 2,  32'h22,       2, 0};
    tbl[9]  = '{1, 4, 32'h44, 1, 22, 32'hA2,          1, 3,  32'h33,       2, 0};
    tbl[10] = '{0, 0, 0, 1, 22, 32'hA2,               1, 4,  32'h44,       2, 0};
    tbl[11] = '{0, 0, 0, 1, 22, 32'hA2,               1, 20, 32'hA0,       1, 1};
    tbl[12] = '{0, 0, 0, 0, 0, 0,                     1, 21, 32'hA1,       1, 1};
    tbl[13] = '{0, 0, 0, 0, 0, 0,                     1, 22, 32'hA2,       0, 1};
    tbl[14] = '{1, 0, 32'h99, 1, 0, 32'h77,           0, 22, 32'hA2,       0, 1};
    tbl[15] = '{0, 0, 0, 0, 0, 0,                     0, 0,  32'h99,       1, 1};
    tbl[16] = '{0, 0, 0, 0, 0, 0,                     0, 0,  32'h77,       0, 1};
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].iv, tbl[i].ia, tbl[i].id, tbl[i].mv, tbl[i].ma, tbl[i].md);
      #4;
      chk($sformatf("v%0d_wen", i), o_rf_wen, tbl[i].wen);
      chk($sformatf("v%0d_waddr", i), o_rf_waddr, tbl[i].wa);
      chk($sformatf("v%0d_wdata", i), o_rf_wdata, tbl[i].wd);
      chk($sformatf("v%0d_count", i), o_mem_count, tbl[i].cnt);
      chk($sformatf("v%0d_ready", i), o_mem_ready, tbl[i].rdy);
      @(posedge clk); #1;
    end
    do_reset();
    step(1, 3, 32'h55, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 9, 32'h9, 1, 25, 32'hB5);
    step(1, 9, 32'h9, 1, 26, 32'hB6);
    step(1, 9, 32'h9, 0, 0, 0);
    #4;
    chk("pre_rst_count", o_mem_count, 2);
    @(posedge clk); #1;
    do_reset();
    repeat (3) step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      logic [4:0] ma;
      if ($urandom_range(0, 39) == 0) do_reset();
      ma = 5'($urandom_range(15, 31));
      if (ma == 15) ma = 0;
      step($urandom_range(0, 1) == 1, 5'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 9) < 6, ma, $urandom);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
